// File: rtl/datamem_pipe.sv
// Pipelined byte-addressed little-endian data memory for the MEM stage:
// valid/ready requests, fixed-latency in-order responses, sign/zero-extended loads, in-band faults.
module datamem_pipe #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_BYTES      = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BYTES         = DATA_WIDTH / 8,
    localparam int SW            = $clog2($clog2(BYTES) + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [63:0]           req_addr,
    input  logic [SW-1:0]         req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_write,
    output logic                  resp_error,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  fault_sticky,
    output logic [63:0]           fault_addr,
    input  logic                  fault_clear,
    output logic                  clearing
);

    localparam int MAXS  = $clog2(BYTES);
    localparam int WORDS = MEM_BYTES / BYTES;
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [WIW-1:0]        sweep_q, sweep_d;
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  accept_s, fault_s, wr_en_s;
    logic [64:0]           end_s;
    logic [WIW-1:0]        widx_s;
    logic [MAXS-1:0]       off_s;
    logic [BYTES-1:0]      lane_en_s;
    logic [DATA_WIDTH-1:0] wdata_sh_s, raw_s, load_s;

    logic                  pv_q [READ_LATENCY];
    logic                  pw_q [READ_LATENCY];
    logic                  pe_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY];
    logic                  pv_d, pw_d, pe_d;
    logic [DATA_WIDTH-1:0] pd_d;

    logic                  sticky_q, sticky_d;
    logic [63:0]           faddr_q, faddr_d;

    // Keep the low 8<<size bits of the lane-aligned word, then zero- or sign-fill above.
    function automatic logic [DATA_WIDTH-1:0] ext_load(input logic [DATA_WIDTH-1:0] raw,
                                                       input logic [SW-1:0]         size,
                                                       input logic                  sgn);
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] res;
        mask = '0;
        res  = raw;
        for (int k = 0; k < MAXS; k++) begin
            if (size == SW'(k)) begin
                mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << k));
                res  = raw & mask;
                if (sgn && raw[(8 << k) - 1]) begin
                    res = res | ~mask;
                end else begin
                    res = raw & mask;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Request decode: fault check, word/lane selection, store enables and load data.
    always_comb begin
        accept_s   = req_valid && (state_q == ST_RUN);
        end_s      = {1'b0, req_addr} + (65'd1 << req_size);
        fault_s    = (req_size > SW'(MAXS))
                   || ((req_addr & ((64'd1 << req_size) - 64'd1)) != 64'd0)
                   || (end_s > 65'(MEM_BYTES));
        wr_en_s    = accept_s && req_write && !fault_s;
        widx_s     = req_addr[MAXS +: WIW];
        off_s      = req_addr[MAXS-1:0];
        wdata_sh_s = req_wdata << {off_s, 3'b000};
        lane_en_s  = '0;
        for (int j = 0; j < BYTES; j++) begin
            lane_en_s[j] = (32'(j) >= 32'(off_s)) && (32'(j) < 32'(off_s) + (32'd1 << req_size));
        end
        raw_s  = mem[widx_s] >> {off_s, 3'b000};
        load_s = ext_load(raw_s, req_size, req_signed);
    end

    // Storage array: zero-fill sweep word, else byte-lane store. Never reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[sweep_q] <= '0;
        end else if (wr_en_s) begin
            for (int j = 0; j < BYTES; j++) begin
                if (lane_en_s[j]) begin
                    mem[widx_s][8*j +: 8] <= wdata_sh_s[8*j +: 8];
                end
            end
        end
    end

    // Sweep/run controller next state.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_q == WIW'(WORDS - 1)) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end else begin
                    state_d = ST_CLEAR;
                    sweep_d = sweep_q + WIW'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // First pipeline stage contents and fault capture; a fault this cycle beats fault_clear.
    always_comb begin
        pv_d = accept_s;
        pw_d = accept_s && req_write;
        pe_d = accept_s && fault_s;
        if (accept_s && !fault_s && !req_write) begin
            pd_d = load_s;
        end else begin
            pd_d = '0;
        end
        if (accept_s && fault_s && (!sticky_q || fault_clear)) begin
            sticky_d = 1'b1;
            faddr_d  = req_addr;
        end else if (fault_clear) begin
            sticky_d = 1'b0;
            faddr_d  = 64'd0;
        end else begin
            sticky_d = sticky_q;
            faddr_d  = faddr_q;
        end
    end

    // Response pipeline and fault registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pw_q[i] <= 1'b0;
                pe_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
            sticky_q <= 1'b0;
            faddr_q  <= 64'd0;
        end else begin
            pv_q[0] <= pv_d;
            pw_q[0] <= pw_d;
            pe_q[0] <= pe_d;
            pd_q[0] <= pd_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pw_q[i] <= pw_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
            sticky_q <= sticky_d;
            faddr_q  <= faddr_d;
        end
    end

    assign req_ready    = (state_q == ST_RUN);
    assign clearing     = (state_q == ST_CLEAR);
    assign resp_valid   = pv_q[READ_LATENCY-1];
    assign resp_write   = pw_q[READ_LATENCY-1];
    assign resp_error   = pe_q[READ_LATENCY-1];
    assign resp_rdata   = pd_q[READ_LATENCY-1];
    assign fault_sticky = sticky_q;
    assign fault_addr   = faddr_q;

endmodule

// File: tb/tb_datamem_pipe.sv
// Directed bench for datamem_pipe: a 64-bit/1 KiB/latency-1 instance and a 128-bit/256 B/latency-3 instance.
module tb_datamem_pipe;

    localparam int LA = 1;
    localparam int LB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         a_valid, a_ready, a_write, a_signed, a_rvalid, a_rwrite, a_rerr, a_sticky, a_fclr, a_clearing;
    logic [63:0]  a_addr, a_wdata, a_rdata, a_faddr;
    logic [1:0]   a_size;

    logic         b_valid, b_ready, b_write, b_signed, b_rvalid, b_rwrite, b_rerr, b_sticky, b_fclr, b_clearing;
    logic [63:0]  b_addr, b_faddr;
    logic [127:0] b_wdata, b_rdata;
    logic [2:0]   b_size;

    datamem_pipe #(.DATA_WIDTH(64), .MEM_BYTES(1024), .READ_LATENCY(LA), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_addr(a_addr), .req_size(a_size), .req_signed(a_signed), .req_wdata(a_wdata),
        .resp_valid(a_rvalid), .resp_write(a_rwrite), .resp_error(a_rerr), .resp_rdata(a_rdata),
        .fault_sticky(a_sticky), .fault_addr(a_faddr), .fault_clear(a_fclr), .clearing(a_clearing));

    datamem_pipe #(.DATA_WIDTH(128), .MEM_BYTES(256), .READ_LATENCY(LB), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_size(b_size), .req_signed(b_signed), .req_wdata(b_wdata),
        .resp_valid(b_rvalid), .resp_write(b_rwrite), .resp_error(b_rerr), .resp_rdata(b_rdata),
        .fault_sticky(b_sticky), .fault_addr(b_faddr), .fault_clear(b_fclr), .clearing(b_clearing));

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0]  tb_mem [1024];
    logic [65:0] expq [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference for the 64-bit instance: byte array, little-endian, faults per alignment/bounds.
    function automatic logic [65:0] model(input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                                          input logic sg, input logic [63:0] wd);
        int n = 1 << sz;
        logic [63:0] r = 64'd0;
        logic err = ((addr % 64'(n)) != 64'd0) || ((addr + 64'(n)) > 64'd1024);
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) tb_mem[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) r[8*i +: 8] = tb_mem[int'(addr) + i];
                if (sg && n < 8 && r[8*n-1]) for (int k = 8*n; k < 64; k++) r[k] = 1'b1;
            end
        end
        return {err, wr, r};
    endfunction

    task automatic a_req(input string tag, input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                         input logic sg, input logic [63:0] wd, input logic fclr,
                         input logic exp_err, input logic [63:0] exp_data);
        @(negedge clk);
        a_valid = 1'b1; a_write = wr; a_addr = addr; a_size = sz; a_signed = sg; a_wdata = wd; a_fclr = fclr;
        @(posedge clk); #1;
        a_valid = 1'b0; a_fclr = 1'b0;
        for (int k = 1; k < LA; k++) begin
            check({tag, " early"}, a_rvalid, 1'b0);
            @(posedge clk); #1;
        end
        check({tag, " valid"}, a_rvalid, 1'b1);
        check({tag, " resp"}, {a_rerr, a_rwrite, a_rdata}, {exp_err, wr, exp_data});
        @(posedge clk); #1;
        check({tag, " pulse"}, a_rvalid, 1'b0);
    endtask

    task automatic b_req(input string tag, input logic wr, input logic [63:0] addr, input logic [2:0] sz,
                         input logic sg, input logic [127:0] wd,
                         input logic exp_err, input logic [127:0] exp_data);
        @(negedge clk);
        b_valid = 1'b1; b_write = wr; b_addr = addr; b_size = sz; b_signed = sg; b_wdata = wd;
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int k = 1; k < LB; k++) begin
            check({tag, " early"}, b_rvalid, 1'b0);
            @(posedge clk); #1;
        end
        check({tag, " valid"}, b_rvalid, 1'b1);
        check({tag, " resp"}, {b_rerr, b_rwrite, b_rdata}, {exp_err, wr, exp_data});
        @(posedge clk); #1;
        check({tag, " pulse"}, b_rvalid, 1'b0);
    endtask

    // Counts cycles until each instance leaves the sweep, and response pulses seen meanwhile.
    task automatic wait_sweep(input string tag, input int exp_a, input int exp_b);
        int ca = -1;
        int cb = -1;
        int pulses = 0;
        for (int cyc = 1; cyc <= 400 && (ca < 0 || cb < 0); cyc++) begin
            @(posedge clk); #1;
            if (a_rvalid || b_rvalid) pulses++;
            if (ca < 0 && a_ready) ca = cyc;
            if (cb < 0 && b_ready) cb = cyc;
        end
        check({tag, " sweep64"}, ca, exp_a);
        check({tag, " sweep128"}, cb, exp_b);
        check({tag, " no resp"}, pulses, 0);
        check({tag, " clearing"}, {a_clearing, b_clearing}, 2'b00);
    endtask

    localparam logic [127:0] W16 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    initial begin
        a_valid = 1'b0; a_write = 1'b0; a_addr = 64'd0; a_size = 2'd0; a_signed = 1'b0; a_wdata = 64'd0; a_fclr = 1'b0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 64'd0; b_size = 3'd0; b_signed = 1'b0; b_wdata = 128'd0; b_fclr = 1'b0;
        for (int i = 0; i < 1024; i++) tb_mem[i] = 8'd0;
        #1 rst_n = 1'b0;
        #11;
        check("rst outs", {a_rvalid, a_rwrite, a_rerr, a_sticky, a_ready, a_clearing}, 6'b000001);
        check("rst data", {a_rdata, a_faddr}, 128'd0);
        check("rst b", {b_rvalid, b_ready, b_clearing}, 3'b001);

        // Release, restart the sweep partway through, then time the full sweep.
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wait_sweep("init", 128, 16);

        a_req("top", 1'b0, 64'h3F8, 2'd3, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        a_req("st8", 1'b1, 64'h10, 2'd3, 1'b0, 64'h8877665544332211, 1'b0, 1'b0, 64'd0);
        a_req("lbs", 1'b0, 64'h17, 2'd0, 1'b1, 64'd0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFF88);
        a_req("lbu", 1'b0, 64'h17, 2'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'h88);
        a_req("lhu", 1'b0, 64'h16, 2'd1, 1'b0, 64'd0, 1'b0, 1'b0, 64'h8877);
        a_req("lws", 1'b0, 64'h14, 2'd2, 1'b1, 64'd0, 1'b0, 1'b0, 64'hFFFFFFFF88776655);
        a_req("ld8s", 1'b0, 64'h10, 2'd3, 1'b1, 64'd0, 1'b0, 1'b0, 64'h8877665544332211);

        // Store then load of the same word on consecutive edges.
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 64'h20; a_size = 2'd2; a_signed = 1'b0; a_wdata = 64'hCAFEF00DDEADBEEF;
        @(posedge clk); #1;
        check("b2b st", {a_rvalid, a_rerr, a_rwrite, a_rdata}, {3'b101, 64'd0});
        @(negedge clk);
        a_write = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("b2b ld", {a_rvalid, a_rerr, a_rwrite, a_rdata}, {3'b100, 64'h00000000DEADBEEF});
        a_req("ld8 20", 1'b0, 64'h20, 2'd3, 1'b0, 64'd0, 1'b0, 1'b0, 64'h00000000DEADBEEF);

        // Faults, sticky capture and clear.
        a_req("mis", 1'b0, 64'h22, 2'd2, 1'b0, 64'd0, 1'b0, 1'b1, 64'd0);
        check("mis sticky", {a_sticky, a_faddr}, {1'b1, 64'h22});
        a_req("oob", 1'b1, 64'h400, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 64'd0);
        check("oob keep", {a_sticky, a_faddr}, {1'b1, 64'h22});
        a_req("nowrap", 1'b0, 64'h0, 2'd3, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        a_req("edge ok", 1'b0, 64'h3FC, 2'd2, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        @(negedge clk) a_fclr = 1'b1;
        @(posedge clk); #1 a_fclr = 1'b0;
        check("clear", {a_sticky, a_faddr}, {1'b0, 64'd0});
        a_req("mis2", 1'b0, 64'h22, 2'd2, 1'b0, 64'd0, 1'b0, 1'b1, 64'd0);
        a_req("clr+flt", 1'b0, 64'h31, 2'd1, 1'b0, 64'd0, 1'b1, 1'b1, 64'd0);
        check("clr+flt wins", {a_sticky, a_faddr}, {1'b1, 64'h31});

        // Wide instance, latency 3.
        b_req("b st16", 1'b1, 64'h20, 3'd4, 1'b0, W16, 1'b0, 128'd0);
        b_req("b ld16", 1'b0, 64'h20, 3'd4, 1'b1, 128'd0, 1'b0, W16);
        b_req("b lbs", 1'b0, 64'h27, 3'd0, 1'b1, 128'd0, 1'b0, {{120{1'b1}}, 8'hFE});
        b_req("b lhs", 1'b0, 64'h2E, 3'd1, 1'b1, 128'd0, 1'b0, 128'h0123);
        b_req("b lws", 1'b0, 64'h24, 3'd2, 1'b1, 128'd0, 1'b0, {{96{1'b1}}, 32'hFEDCBA98});
        b_req("b top", 1'b0, 64'hF0, 3'd4, 1'b0, 128'd0, 1'b0, 128'd0);
        b_req("b oob", 1'b1, 64'h100, 3'd4, 1'b0, W16, 1'b1, 128'd0);
        check("b oob sticky", {b_sticky, b_faddr}, {1'b1, 64'h100});
        b_req("b sz5", 1'b0, 64'h0, 3'd5, 1'b0, 128'd0, 1'b1, 128'd0);

        // Reset with three loads in flight on the latency-3 instance.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_valid = 1'b1; b_write = 1'b0; b_addr = 64'h20; b_size = 3'd4; b_signed = 1'b0;
            @(posedge clk);
        end
        #1 b_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid rst", {b_rvalid, b_sticky, b_ready, b_clearing, a_sticky}, 5'b00010);
        repeat (2) begin
            @(posedge clk); #1;
            check("mid rst hold", {a_rvalid, b_rvalid}, 2'b00);
        end
        @(negedge clk) rst_n = 1'b1;
        wait_sweep("mid", 128, 16);
        a_req("swept a", 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        b_req("swept b", 1'b0, 64'h20, 3'd4, 1'b0, 128'd0, 1'b0, 128'd0);

        // Random stream, valid held high, against the byte-array reference.
        for (int i = 0; i < 64; i++) begin
            logic [1:0]  sz;
            logic [63:0] addr;
            @(negedge clk);
            sz   = 2'($urandom_range(0, 3));
            addr = 64'($urandom_range(0, 47));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            if (i % 16 == 15) addr = 64'h400 - (64'($urandom_range(0, 1)) << sz);
            a_valid  = 1'b1;
            a_write  = ($urandom_range(0, 1) == 1);
            a_addr   = addr;
            a_size   = sz;
            a_signed = ($urandom_range(0, 1) == 1);
            a_wdata  = {$urandom, $urandom};
            expq.push_back(model(a_write, a_addr, a_size, a_signed, a_wdata));
            @(posedge clk); #1;
            check("stream valid", a_rvalid, 1'b1);
            if (expq.size() != 0) check("stream resp", {a_rerr, a_rwrite, a_rdata}, expq.pop_front());
        end
        @(negedge clk) a_valid = 1'b0;
        @(posedge clk); #1;
        check("stream end", {a_rvalid, 32'(expq.size())}, 33'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion (%0d/%0d checks passed)", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/datamem_pipe.md
Name: datamem_pipe

Overview:
Parametrised, pipelined successor to the team's byte-addressed little-endian data memory, built for the 5-stage pipeline's MEM stage. Requests use a valid/ready handshake and complete with a fixed READ_LATENCY. It adds sign/zero-extended loads, an optional zero-fill sweep after reset, and in-band fault reporting in place of simulation asserts. Data width and memory size are configurable.

Parameters:
DATA_WIDTH, 64, word width in bits; power of two, 16..128.
MEM_BYTES, 1024, storage size in bytes; power of two, > DATA_WIDTH/8.
READ_LATENCY, 1, cycles from acceptance edge to response; 1..4.
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset before accepting requests.
Derived: BYTES = DATA_WIDTH/8; SW = $clog2($clog2(BYTES)+1).

Ports:
clk  in  1  clock, all state on posedge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_addr  in  64  byte address.
req_size  in  SW  log2 of transfer bytes (0 = 1 B ... $clog2(BYTES) = full word).
req_signed  in  1  loads only: sign-extend the result.
req_wdata  in  DATA_WIDTH  store data, low 8<<req_size bits used.
resp_valid  out  1  one-cycle response pulse.
resp_write  out  1  echo of req_write for this response.
resp_error  out  1  request faulted.
resp_rdata  out  DATA_WIDTH  load result; 0 for stores and faults.
fault_sticky  out  1  set on the first fault; held until fault_clear.
fault_addr  out  64  req_addr of the first fault since last clear.
fault_clear  in  1  synchronous clear of fault_sticky and fault_addr.
clearing  out  1  zero-fill sweep in progress.

Behaviour:
- Reset (reset_n low, async): resp_valid=0, resp_write=0, resp_error=0, resp_rdata=0, fault_sticky=0, fault_addr=0, all pipeline valids=0. The array is not reset. State = CLEAR if CLEAR_ON_RESET, else RUN.
- FSM CLEAR: one BYTES-wide word at index sweep_idx (0..MEM_BYTES/BYTES-1) is zeroed per cycle. Then RUN. clearing=1 and req_ready=0 throughout. Sweep takes exactly MEM_BYTES/BYTES cycles. Reset during the sweep restarts it at 0.
- FSM RUN: req_ready=1 every cycle, with no request-side stall. Throughput is one request per cycle.
- Acceptance: req_valid && req_ready at edge N. At edge N+READ_LATENCY, resp_valid=1 for one cycle. Responses are returned in order. The response side has no backpressure.
- Fault check at acceptance, evaluated in order, any true = fault:
  - req_size > $clog2(BYTES);
  - req_addr[req_size-1:0] != 0 (misaligned);
  - req_addr + (1<<req_size) > MEM_BYTES (computed in 65 bits, so no wrap).
- Faulted request: no array write; resp_error=1 and resp_rdata=0. If fault_sticky==0, capture fault_addr and set fault_sticky.
- Store: bytes addr..addr+(1<<size)-1 are written at acceptance edge N from req_wdata little-endian (byte i = wdata[8i+7:8i]).
- Load: array bytes are sampled at edge N into the pipeline. Bits above 8<<size are zero, or copies of bit (8<<size)-1 when req_signed. req_signed is ignored for full-word loads and for stores.
- Read-after-write: a load accepted at N+1 to a byte stored at N returns the new data.
- fault_clear and a new fault in the same cycle: the new fault wins (sticky set, address captured).
- Reset mid-pipeline: all in-flight responses are dropped, with no resp_valid after reset.

Test Plan:
- Sweep after reset: CLEAR_ON_RESET=1, reset_n low→high → req_ready low for 128 cycles (64-bit, 1024 B); then a 64-bit load of addr 0x3F8 → resp_rdata=0, resp_error=0.
- Latency and extension: store 8 B 0x8877665544332211 @0x10, then load size=0 @0x17 signed → 0xFFFFFFFFFFFFFF88; load size=1 @0x16 unsigned → 0x0000000000008877; each response exactly READ_LATENCY cycles after acceptance (run with READ_LATENCY=1 and 3).
- Back-to-back: store 4 B 0xDEADBEEF @0x20 at edge N, load 4 B @0x20 at N+1 → 0xDEADBEEF; stream of 64 random requests with req_valid held high → one response per cycle, in order, matching a scoreboard.
- Faults: load size=2 @0x22 (misaligned) → resp_error=1, rdata=0, fault_sticky=1, fault_addr=0x22; then store 8 B @0x400 (out of bounds) → error, fault_addr stays 0x22, memory unchanged; fault_clear → sticky=0.
- Reset mid-operation: issue 3 loads, pull reset_n low asynchronously before the first response → no resp_valid pulses, sweep restarts from index 0.
- Parameter sweep: DATA_WIDTH=128, MEM_BYTES=256 → size=4 (16 B) load/store round-trip correct; size=5 → fault.
